// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC and fetch stage feeding decode through a one-entry skid buffer
// A redirect that lands on an outstanding fetch parks in DRAIN until the memory acks.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] IR,
    output logic [31:0] pc_plus4,
    output logic        ir_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} stateType;

    stateType    state, nextState;
    logic [31:0] pc, pcNext;
    logic [31:0] irNext, pcPlus4Next;
    logic        irValidNext;
    logic        skidValid, skidValidNext;
    logic [31:0] skidIr, skidIrNext;
    logic [31:0] skidPcPlus4, skidPcPlus4Next;
    logic [31:0] redirectPc, redirectPcNext;
    logic [31:0] target, pcInc;
    logic        consume;

    assign imem_req  = (state != IDLE);
    assign imem_addr = pc;
    assign target    = branch_target & ~32'h3;
    assign pcInc     = pc + 32'd4;
    assign consume   = ir_valid & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            IR          <= NOP_IR;
            pc_plus4    <= 32'h0;
            ir_valid    <= 1'b0;
            skidValid   <= 1'b0;
            skidIr      <= 32'h0;
            skidPcPlus4 <= 32'h0;
            redirectPc  <= 32'h0;
        end else begin
            state       <= nextState;
            pc          <= pcNext;
            IR          <= irNext;
            pc_plus4    <= pcPlus4Next;
            ir_valid    <= irValidNext;
            skidValid   <= skidValidNext;
            skidIr      <= skidIrNext;
            skidPcPlus4 <= skidPcPlus4Next;
            redirectPc  <= redirectPcNext;
        end
    end

    always_comb begin
        nextState       = state;
        pcNext          = pc;
        irNext          = IR;
        pcPlus4Next     = pc_plus4;
        irValidNext     = ir_valid;
        skidValidNext   = skidValid;
        skidIrNext      = skidIr;
        skidPcPlus4Next = skidPcPlus4;
        redirectPcNext  = redirectPc;

        // Decode taking IR either refills it from the skid or leaves a bubble.
        if (consume) begin
            if (skidValid) begin
                irNext        = skidIr;
                pcPlus4Next   = skidPcPlus4;
                skidValidNext = 1'b0;
            end else begin
                irValidNext = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                if (branch_taken) begin
                    pcNext = target;
                end
                if (!skidValid || branch_taken) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack && !branch_taken) begin
                    pcNext = pcInc;
                    if (!ir_valid || consume) begin
                        irNext      = imem_rdata;
                        pcPlus4Next = pcInc;
                        irValidNext = 1'b1;
                    end else begin
                        skidValidNext   = 1'b1;
                        skidIrNext      = imem_rdata;
                        skidPcPlus4Next = pcInc;
                        nextState       = IDLE;
                    end
                end else if (imem_ack && branch_taken) begin
                    pcNext = target;
                end else if (branch_taken) begin
                    redirectPcNext = target;
                    nextState      = DRAIN;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    redirectPcNext = target;
                end
                if (imem_ack) begin
                    pcNext    = branch_taken ? target : redirectPc;
                    nextState = FETCH;
                end
            end
            default: nextState = IDLE;
        endcase

        // A redirect overrides every other update to the decode-side registers.
        if (branch_taken) begin
            irValidNext   = 1'b0;
            irNext        = NOP_IR;
            skidValidNext = 1'b0;
        end
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decode. Holds the PC and issues word fetches to instruction memory over a req/ack handshake. Presents the fetched word on IR, with its pc_plus4, to the decode/control stage. Absorbs decode stalls with a one-entry skid buffer and handles branch redirects, including redirects that arrive while a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_IR, 32'h0000_0000, IR value while reset is asserted and after a flush.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high.
imem_req  output  1  fetch request; held high with imem_addr stable until imem_ack.
imem_addr  output  32  word address being fetched (always word-aligned).
imem_rdata  input  32  instruction word, valid when imem_ack=1.
imem_ack  input  1  one-cycle completion pulse; may assert the same cycle imem_req first rises (zero wait) or any number of cycles later.
stall  input  1  decode cannot take IR this cycle.
branch_taken  input  1  redirect request; one-cycle pulse.
branch_target  input  32  redirect address; bits [1:0] ignored, forced to 0.
IR  output  32  instruction to decode.
pc_plus4  output  32  address of IR + 4.
ir_valid  output  1  IR holds a live instruction.

Behaviour:
- Reset (asynchronous, immediate): PC=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, IR=NOP_IR, pc_plus4=0, ir_valid=0, skid empty, redirect_pc=0.
- consume = ir_valid & ~stall. When ir_valid=0, stall is ignored.
- imem_req=1 in FETCH and DRAIN, 0 in IDLE. imem_addr=PC at all times.
- IDLE:
  - branch_taken: PC<=target, flush.
  - Go to FETCH when the skid is empty (or is flushed this cycle). Otherwise stay.
- FETCH, imem_ack & ~branch_taken:
  - PC<=PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - Data goes to IR/pc_plus4 if (~ir_valid | consume); otherwise it goes to the skid.
  - Next state FETCH if the skid stays empty, else IDLE.
- FETCH, imem_ack & branch_taken: discard the data, PC<=target, flush, stay in FETCH.
- FETCH, ~imem_ack & branch_taken:
  - redirect_pc<=target, flush, go to DRAIN.
  - PC and imem_addr are unchanged, because the outstanding request cannot be cancelled.
- DRAIN:
  - imem_req stays high at the old address.
  - A further branch_taken overwrites redirect_pc (latest wins) and flushes.
  - On imem_ack: discard the data, PC<=redirect_pc, go to FETCH.
  - If ack and branch_taken occur together, PC<=the new target.
- Flush (any branch_taken): next-cycle ir_valid=0, IR=NOP_IR, skid emptied. Takes priority over consume, capture and skid drain in the same cycle.
- Skid drain: when the skid is full and consume=1 with no branch, IR<=skid contents, ir_valid stays 1, skid empties. Fetch resumes the following cycle via IDLE->FETCH.
- A request is only launched when the skid is empty, so the skid never overflows.
- Latency: ack in cycle N -> IR/ir_valid updated at edge N+1. With zero-wait memory and no stall, throughput is one instruction per cycle.
- IR, pc_plus4, ir_valid, PC and state are all registered. No output depends combinationally on imem_rdata.
- Order preservation: instructions reach IR in fetch order. No instruction is duplicated or lost except by flush.

Test Plan:
- Reset/first fetch: release reset -> first cycle imem_req=0; next cycle req=1, addr=0. Ack one cycle later with 32'h0210_8420 -> following cycle IR=32'h0210_8420, pc_plus4=4, ir_valid=1, imem_addr=4.
- Zero-wait streaming: ack tied high, stall=0 -> addresses 0,4,8,12 on consecutive cycles; IR sequence matches memory one cycle later, with no bubbles.
- Stall plus skid: hold stall=1 with ir_valid=1; ack for addr 8 -> IR unchanged, skid full, imem_req=0. Release stall -> next cycle IR=word@8; the cycle after, req=1 at addr 12.
- Redirect during outstanding fetch: req at addr 8 unacked, branch_taken with target 32'h40 -> ir_valid=0 next cycle, req stays at addr 8. Ack 2 cycles later -> data discarded, next req addr 32'h40, next IR=word@0x40.
- Redirect coincident with ack: ack at addr 4 and branch_taken to 32'h100 in the same cycle -> word@4 never appears on IR; next addr 32'h100. A second branch in DRAIN to 32'h200 wins over the earlier 32'h40.
- Async reset mid-DRAIN or with the skid full: assert reset between clock edges -> imem_req=0, ir_valid=0, IR=NOP_IR, imem_addr=RESET_PC immediately; after release the fetch restarts at RESET_PC.
